// File: rtl/adder_pkg.sv
// Shared constants for the pipelined 4-input adder and its receive-side drain.
package adder_pkg;

    localparam int ADDER_LAT   = 2;
    localparam int ADDER_DSIZE = 64;
    localparam int DRAIN_DEPTH = 4;

endpackage

// File: rtl/adder_sum_drain_sum_fifo.sv
// Single-clock result FIFO; head is read combinationally from the storage array.
module sum_fifo #(
    parameter int DSIZE = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [DSIZE-1:0] wr_data,
    output logic [DSIZE-1:0] head,
    output logic [AW:0]      level,
    output logic             empty,
    output logic             full
);

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == (AW+1)'(DEPTH));
    assign level = level_q;
    assign head  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only honoured when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/adder_sum_drain.sv
// Receive end of the fixed-latency adder: credit-gated issue, latency tracking,
// result capture and a valid/ready drain port.
module adder_sum_drain
    import adder_pkg::*;
#(
    parameter int DSIZE = ADDER_DSIZE,
    parameter int LAT   = ADDER_LAT,
    parameter int DEPTH = DRAIN_DEPTH,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [DSIZE-1:0] sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] out_data,
    output logic [LW-1:0]    level,
    output logic             proto_err
);

    logic [LW-1:0]  credit_q, credit_d;
    logic [LAT-1:0] vld_q, vld_d;
    logic           proto_err_q, proto_err_d;
    logic           acc, pop, push;
    logic           fifo_empty, fifo_full;

    assign issue_ready = (credit_q != '0);
    assign out_valid   = !fifo_empty;
    assign proto_err   = proto_err_q;

    assign acc  = issue_valid && issue_ready;
    assign pop  = out_valid && out_ready;
    assign push = vld_q[LAT-1];

    // Credit tracks free FIFO slots not yet claimed by a beat still in the adder.
    always_comb begin
        credit_d    = credit_q - LW'(acc) + LW'(pop);
        vld_d       = vld_q << 1;
        vld_d[0]    = acc;
        proto_err_d = proto_err_q || (issue_valid && !issue_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q    <= LW'(DEPTH);
            vld_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            credit_q    <= credit_d;
            vld_q       <= vld_d;
            proto_err_q <= proto_err_d;
        end
    end

    sum_fifo #(
        .DSIZE (DSIZE),
        .DEPTH (DEPTH)
    ) u_sum_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (sum),
        .head    (out_data),
        .level   (level),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // The credit scheme must make an unpaired push into a full FIFO impossible.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push && fifo_full && !pop));
        end
    end

endmodule
